// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file.
// Optional build macro REGFILE_BYPASS_EN is consumed by register_file.sv.
package register_file_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int REG_ZERO   = 0;
  localparam int WR_COUNT_W = 16;
  localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = '1;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/register_file_if.sv
// Writeback/reserve/read bundle between pipeline control and the register file.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DW-1:0]         wdata;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic [AW-1:0]         raddr0;
  logic [AW-1:0]         raddr1;
  logic [DW-1:0]         rdata0;
  logic [DW-1:0]         rdata1;
  logic                  busy0;
  logic                  busy1;
  logic [WR_COUNT_W-1:0] wr_count;

  modport master (
    output we, waddr, wdata, rsv_en, rsv_addr, raddr0, raddr1,
    input  rdata0, rdata1, busy0, busy1, wr_count
  );
  modport slave (
    input  we, waddr, wdata, rsv_en, rsv_addr, raddr0, raddr1,
    output rdata0, rdata1, busy0, busy1, wr_count
  );
endinterface

// File: rtl/register_file_wr_decode.sv
// ADDR_W-to-one-hot decoder with enable; bit 0 is forced low (register 0 is hardwired).
module regfile_wr_decode #(
  parameter int ADDR_W = 5
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
    onehot[0] = 1'b0;
  end
endmodule

// File: rtl/register_file.sv
// 2R1W register file with per-register busy scoreboard and saturating write counter.
// Define REGFILE_BYPASS_EN for same-cycle write-through onto the read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input logic clk,
  input logic rst_n,
  register_file_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] rf;
  logic [NREG-1:0]             busy;
  logic [NREG-1:0]             wsel;
  logic [NREG-1:0]             rsel;
  logic [WR_COUNT_W-1:0]       cnt;

  regfile_wr_decode #(.ADDR_W(ADDR_W)) u_wdec (
    .en     (bus.we),
    .addr   (bus.waddr),
    .onehot (wsel)
  );

  always_comb begin
    rsel = '0;
    if (bus.rsv_en) rsel[bus.rsv_addr] = 1'b1;
    rsel[REG_ZERO] = 1'b0;
  end

  // Reserve beats writeback clear: a newer instruction already owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf   <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wsel[i]) rf[i] <= bus.wdata;
        if (rsel[i])      busy[i] <= 1'b1;
        else if (wsel[i]) busy[i] <= 1'b0;
      end
      if (|wsel && cnt != WR_COUNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  assign bus.wr_count = cnt;

`ifdef REGFILE_BYPASS_EN
  // wsel[raddrN] is set only for an accepted write to that same register.
  assign bus.rdata0 = wsel[bus.raddr0] ? bus.wdata : rf[bus.raddr0];
  assign bus.rdata1 = wsel[bus.raddr1] ? bus.wdata : rf[bus.raddr1];
  assign bus.busy0  = wsel[bus.raddr0] ? 1'b0 : busy[bus.raddr0];
  assign bus.busy1  = wsel[bus.raddr1] ? 1'b0 : busy[bus.raddr1];
`else
  assign bus.rdata0 = rf[bus.raddr0];
  assign bus.rdata1 = rf[bus.raddr1];
  assign bus.busy0  = busy[bus.raddr0];
  assign bus.busy1  = busy[bus.raddr1];
`endif
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Write-side counterpart of the processor's 32-bit 2:1 select path.
- A 1:32 write demultiplexer steers one 32-bit result into the addressed architectural register.
- Two read ports feed the ALU operand muxes.
- A per-register busy scoreboard flags registers with an outstanding write. Sits between decode/writeback and the execute-stage operand muxes.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count = 2**ADDR_W

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- we  input  1  write enable for the writeback port
- waddr  input  ADDR_W  writeback destination register
- wdata  input  DATA_W  writeback data
- rsv_en  input  1  reserve request: marks rsv_addr busy (issued instruction will write it)
- rsv_addr  input  ADDR_W  register to reserve
- raddr0  input  ADDR_W  read port 0 address (rs)
- raddr1  input  ADDR_W  read port 1 address (rt)
- rdata0  output  DATA_W  read port 0 data
- rdata1  output  DATA_W  read port 1 data
- busy0  output  1  raddr0 has an outstanding reservation
- busy1  output  1  raddr1 has an outstanding reservation
- wr_count  output  16  count of committed writes since reset, saturating

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low. Assertion immediately clears all registers, all busy bits and wr_count to 0, independent of clk.
- Reset outputs: rdata0, rdata1, busy0, busy1 and wr_count all read 0 while rst_n = 0 and after release until written.
- Reads: combinational, zero latency. rdataN = reg[raddrN]; busyN = busy[raddrN].
- Write: on posedge with we = 1 and waddr != 0, reg[waddr] <= wdata, visible on read ports the next cycle.
- Register 0: hardwired to 0. Writes are ignored, reservations are ignored, busy[0] is always 0, and reads of register 0 return 0.
- Write demux: a one-hot decode of waddr gated by we. Exactly one register updates per write.
- Reservation: on posedge with rsv_en = 1 and rsv_addr != 0, busy[rsv_addr] <= 1.
- Writeback clears busy: on posedge with we = 1 and waddr != 0, busy[waddr] <= 0.
- Simultaneous reserve and write to the same address: reserve wins, busy stays 1 (a newer instruction owns the register). The data write still occurs.
- Simultaneous reserve and write to different addresses: both take effect.
- Write to a non-busy register: accepted, busy stays 0.
- wr_count: increments on every accepted write (we = 1, waddr != 0). It saturates at 16'hFFFF and does not wrap.
- Reset mid-operation: any in-flight write or reserve in the same cycle is discarded. State returns to all-zero.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (write-through bypass): if we = 1, waddr != 0 and raddrN == waddr, then rdataN = wdata and busyN = 0 in the same cycle. Supports same-cycle writeback to decode.
- Undefined: reads return stored contents only. New data appears one cycle after the write edge.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO = 0, WR_COUNT_W = 16 and WR_COUNT_MAX constants.
- Sub-module: regfile_wr_decode, a parameterised ADDR_W-to-one-hot decoder with enable and forced-zero bit 0. It is instantiated once and drives both the data-write and busy-clear enables.

Test Plan:
- Reset and read: rst_n = 0 for 3 cycles, then release. Read registers 0 through 31 -> rdata = 0, busy = 0, wr_count = 0.
- Write and read back: we = 1, waddr = 5, wdata = 32'h0000_0005. Next cycle raddr0 = 5 -> rdata0 = 32'h5, wr_count = 1. A write to register 0 with 32'hDEAD_BEEF -> rdata = 0, wr_count unchanged.
- Scoreboard: rsv_en with rsv_addr = 8 -> busy0 = 1 at raddr0 = 8. Then we with waddr = 8 -> busy0 = 0 next cycle. Same-cycle rsv_addr = 8 and waddr = 8 -> busy stays 1 and data is updated.
- Bypass: with REGFILE_BYPASS_EN defined, we with waddr = 3, wdata = 32'hA5A5_A5A5 and raddr1 = 3 in the same cycle -> rdata1 = 32'hA5A5_A5A5 combinationally. Without the macro -> rdata1 = old value that cycle, new value the next.
- Async reset mid-write: drop rst_n between clock edges after loading register 7 = 32'h1234 -> rdata = 0 immediately, without waiting for a clk edge. Busy bits clear.
- Saturation: force or perform 65,536 writes -> wr_count holds 16'hFFFF and does not wrap to 0.
